// File: rtl/frac_clk_div_pkg.sv
// Shared constants and ratio legality rule for the fractional clock-enable generator.
package frac_clk_div_pkg;

    localparam int FCD_ACC_W   = 16;
    localparam int FCD_DEF_NUM = 4;
    localparam int FCD_DEF_DEN = 5;

    // Outcome of a config offer in the current cycle
    typedef enum logic [1:0] {
        CFG_NONE   = 2'd0,
        CFG_ACCEPT = 2'd1,
        CFG_REJECT = 2'd2
    } cfg_action_e;

    // A ratio is usable only if it divides down (num <= den) and neither term is zero.
    // Arguments are 32 bits wide, so callers zero-extend; accumulator widths above 32 are not supported.
    function automatic logic ratio_legal(input logic [31:0] num, input logic [31:0] den);
        return (den != 32'd0) && (num != 32'd0) && (num <= den);
    endfunction

endpackage

// File: rtl/frac_phase_accum.sv
// Phase accumulator: owns the active ratio, the accumulator and the registered tick/clk outputs.
module frac_phase_accum
    import frac_clk_div_pkg::*;
#(
    parameter int ACC_W   = FCD_ACC_W,
    parameter int DEF_NUM = FCD_DEF_NUM,
    parameter int DEF_DEN = FCD_DEF_DEN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_num_i,
    input  logic [ACC_W-1:0] load_den_i,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             clk_o,
    output logic [ACC_W-1:0] num_o,
    output logic [ACC_W-1:0] den_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic [ACC_W:0]   sum;

    // One extra bit keeps acc + num from overflowing before the compare
    assign sum    = {1'b0, acc_q} + {1'b0, num_q};
    assign wrap_o = (sum >= {1'b0, den_q});

    // Next phase: advance when running, then let a ratio load restart the phase from zero
    always_comb begin
        acc_d  = acc_q;
        num_d  = num_q;
        den_d  = den_q;
        tick_d = 1'b0;
        clk_d  = clk_q;
        if (!hold_i) begin
            if (wrap_o) begin
                acc_d  = ACC_W'(sum - {1'b0, den_q});
                tick_d = 1'b1;
                clk_d  = ~clk_q;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
        if (load_i) begin
            acc_d = '0;
            num_d = load_num_i;
            den_d = load_den_i;
        end
    end

    // Register phase, ratio and outputs; reset restores the default ratio
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            num_q  <= ACC_W'(DEF_NUM);
            den_q  <= ACC_W'(DEF_DEN);
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            num_q  <= num_d;
            den_q  <= den_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick_o = tick_q;
    assign clk_o  = clk_q;
    assign num_o  = num_q;
    assign den_o  = den_q;

endmodule

// File: rtl/frac_clk_div.sv
// Fractional clock-enable generator: config handshake, validation and glitch-free ratio switching.
module frac_clk_div
    import frac_clk_div_pkg::*;
#(
    parameter int ACC_W   = FCD_ACC_W,
    parameter int DEF_NUM = FCD_DEF_NUM,
    parameter int DEF_DEN = FCD_DEF_DEN
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    output logic             cfg_err,
    output logic             tick,
    output logic             clk_out,
    output logic [ACC_W-1:0] active_num,
    output logic [ACC_W-1:0] active_den
);

    logic             pending_q, pending_d;
    logic             cfgErr_q, cfgErr_d;
    logic [ACC_W-1:0] shadowNum_q, shadowNum_d;
    logic [ACC_W-1:0] shadowDen_q, shadowDen_d;
    logic             wrap;
    logic             load;
    cfg_action_e      cfgAction;

    // A staged ratio goes live on the next wrap while running, or right away while stopped
    assign load      = pending_q && (!en || wrap);
    assign cfg_ready = !pending_q;
    assign cfg_err   = cfgErr_q;

    frac_phase_accum #(
        .ACC_W   (ACC_W),
        .DEF_NUM (DEF_NUM),
        .DEF_DEN (DEF_DEN)
    ) u_accum (
        .clk_i      (clk_in),
        .rst_ni     (reset),
        .hold_i     (!en),
        .load_i     (load),
        .load_num_i (shadowNum_q),
        .load_den_i (shadowDen_q),
        .wrap_o     (wrap),
        .tick_o     (tick),
        .clk_o      (clk_out),
        .num_o      (active_num),
        .den_o      (active_den)
    );

    // Classify an offer; offers while a ratio is staged are simply not taken
    always_comb begin
        cfgAction = CFG_NONE;
        if (cfg_valid && !pending_q) begin
            if (ratio_legal(32'(cfg_num), 32'(cfg_den))) begin
                cfgAction = CFG_ACCEPT;
            end else begin
                cfgAction = CFG_REJECT;
            end
        end
    end

    // Stage accepted ratios, flag rejected ones, release the stage once loaded
    always_comb begin
        pending_d   = pending_q;
        shadowNum_d = shadowNum_q;
        shadowDen_d = shadowDen_q;
        cfgErr_d    = 1'b0;
        case (cfgAction)
            CFG_ACCEPT: begin
                shadowNum_d = cfg_num;
                shadowDen_d = cfg_den;
                pending_d   = 1'b1;
            end
            CFG_REJECT: begin
                cfgErr_d = 1'b1;
            end
            default: begin
            end
        endcase
        if (load) begin
            pending_d = 1'b0;
        end
    end

    // Handshake state registers; reset drops any staged ratio
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            pending_q   <= 1'b0;
            shadowNum_q <= '0;
            shadowDen_q <= '0;
            cfgErr_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            shadowNum_q <= shadowNum_d;
            shadowDen_q <= shadowDen_d;
            cfgErr_q    <= cfgErr_d;
        end
    end

endmodule

// File: tb/tb_frac_clk_div.sv
// Testbench for frac_clk_div: directed scenarios plus random traffic against a reference model.
module tb_frac_clk_div;
    import frac_clk_div_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rstN;
    logic         runEn;
    logic         cfgValid;
    logic         cfgReady;
    logic [W-1:0] cfgNum;
    logic [W-1:0] cfgDen;
    logic         cfgErr;
    logic         tickOut;
    logic         clkOut;
    logic [W-1:0] activeNum;
    logic [W-1:0] activeDen;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit tick;
        bit clk;
        bit ready;
        bit err;
        int num;
        int den;
    } expected_t;

    expected_t sbQ[$];

    // Reference model state
    int mAcc, mNum, mDen, mShN, mShD;
    bit mPend, mTick, mClk, mErr;
    bit pendBefore, wrapNow;
    expected_t eNew;

    frac_clk_div #(
        .ACC_W   (W),
        .DEF_NUM (4),
        .DEF_DEN (5)
    ) dut (
        .clk_in     (clk),
        .reset      (rstN),
        .en         (runEn),
        .cfg_valid  (cfgValid),
        .cfg_ready  (cfgReady),
        .cfg_num    (cfgNum),
        .cfg_den    (cfgDen),
        .cfg_err    (cfgErr),
        .tick       (tickOut),
        .clk_out    (clkOut),
        .active_num (activeNum),
        .active_den (activeDen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v, input int n, input int d);
        rstN     = r;
        runEn    = e;
        cfgValid = v;
        cfgNum   = W'(n);
        cfgDen   = W'(d);
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: accumulate num, wrap at den, switch ratio at the handshake points
    always @(posedge clk) begin
        if (!rstN) begin
            mAcc = 0; mNum = 4; mDen = 5; mShN = 0; mShD = 0;
            mPend = 0; mTick = 0; mClk = 0; mErr = 0;
        end else begin
            pendBefore = mPend;
            wrapNow    = runEn && (mAcc + mNum >= mDen);
            mErr       = 0;
            if (wrapNow) begin
                mAcc  = mAcc + mNum - mDen;
                mTick = 1;
                mClk  = !mClk;
            end else begin
                if (runEn) mAcc = mAcc + mNum;
                mTick = 0;
            end
            if (pendBefore && (!runEn || wrapNow)) begin
                mAcc = 0; mNum = mShN; mDen = mShD; mPend = 0;
            end
            if (cfgValid && !pendBefore) begin
                if (cfgDen != 0 && cfgNum != 0 && cfgNum <= cfgDen) begin
                    mShN = int'(cfgNum); mShD = int'(cfgDen); mPend = 1;
                end else begin
                    mErr = 1;
                end
            end
        end
        eNew.tick  = mTick;
        eNew.clk   = mClk;
        eNew.ready = !mPend;
        eNew.err   = mErr;
        eNew.num   = mNum;
        eNew.den   = mDen;
        sbQ.push_back(eNew);
    end

    // Monitor: compare every registered output against the model once per cycle
    always @(negedge clk) begin
        expected_t e;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("sb_tick", 32'(tickOut), 32'(e.tick));
            checkOutput("sb_clk_out", 32'(clkOut), 32'(e.clk));
            checkOutput("sb_cfg_ready", 32'(cfgReady), 32'(e.ready));
            checkOutput("sb_cfg_err", 32'(cfgErr), 32'(e.err));
            checkOutput("sb_active_num", 32'(activeNum), 32'(e.num));
            checkOutput("sb_active_den", 32'(activeDen), 32'(e.den));
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by random traffic
    initial begin
        int ticks, toggles, cnt;
        bit prevClk;
        bit seq[4];
        int offN[3];
        int offD[3];

        rstN = 0; runEn = 0; cfgValid = 0; cfgNum = '0; cfgDen = '0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_tick", 32'(tickOut), 0);
        checkOutput("rst_clk_out", 32'(clkOut), 0);
        checkOutput("rst_ready", 32'(cfgReady), 1);
        checkOutput("rst_num", 32'(activeNum), 4);
        checkOutput("rst_den", 32'(activeDen), 5);

        $display("[TB] default 4/5 for 50 cycles");
        ticks = 0; toggles = 0; prevClk = clkOut;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (i < 5) checkOutput("def_pattern", 32'(tickOut), (i == 0) ? 0 : 1);
            ticks += int'(tickOut);
            if (clkOut != prevClk) toggles++;
            prevClk = clkOut;
        end
        checkOutput("def_tick_count", 32'(ticks), 40);
        checkOutput("def_toggle_count", 32'(toggles), 40);

        $display("[TB] illegal offers");
        offN = '{6, 0, 3};
        offD = '{5, 5, 0};
        for (int k = 0; k < 3; k++) begin
            checkOutput("legal_fn", 32'(ratio_legal(32'(offN[k]), 32'(offD[k]))), 0);
            applyStimulus(1, 1, 1, offN[k], offD[k]);
            checkOutput("bad_err_pulse", 32'(cfgErr), 1);
            checkOutput("bad_ready", 32'(cfgReady), 1);
            applyStimulus(1, 1, 0, 0, 0);
            checkOutput("bad_err_clear", 32'(cfgErr), 0);
            checkOutput("bad_num_kept", 32'(activeNum), 4);
        end
        checkOutput("legal_fn_ok", 32'(ratio_legal(32'd7, 32'd7)), 1);

        $display("[TB] switch to 1/2");
        applyStimulus(1, 1, 1, 1, 2);
        checkOutput("half_ready_low", 32'(cfgReady), 0);
        cnt = 0;
        while (!cfgReady && cnt < 20) begin
            applyStimulus(1, 1, 0, 0, 0);
            cnt++;
        end
        checkOutput("half_apply_bound", 32'(cnt < 20), 1);
        checkOutput("half_apply_tick", 32'(tickOut), 1);
        checkOutput("half_num", 32'(activeNum), 1);
        checkOutput("half_den", 32'(activeDen), 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            seq[i] = tickOut;
        end
        checkOutput("half_alt", {28'd0, seq[0], seq[1], seq[2], seq[3]}, 32'b0101);

        $display("[TB] run enable low");
        applyStimulus(1, 1, 0, 0, 0);
        ticks = 0; toggles = 0; prevClk = clkOut;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            ticks += int'(tickOut);
            if (clkOut != prevClk) toggles++;
        end
        checkOutput("hold_ticks", 32'(ticks), 0);
        checkOutput("hold_toggles", 32'(toggles), 0);
        repeat (5) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 3, 7);
        checkOutput("stop_cfg_ready", 32'(cfgReady), 0);
        checkOutput("stop_cfg_old_num", 32'(activeNum), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("stop_cfg_num", 32'(activeNum), 3);
        checkOutput("stop_cfg_den", 32'(activeDen), 7);
        checkOutput("stop_cfg_ready_back", 32'(cfgReady), 1);
        repeat (10) applyStimulus(1, 1, 0, 0, 0);

        $display("[TB] ratio 7/7");
        applyStimulus(1, 1, 1, 7, 7);
        cnt = 0;
        while (!cfgReady && cnt < 20) begin
            applyStimulus(1, 1, 0, 0, 0);
            cnt++;
        end
        checkOutput("full_apply_bound", 32'(cnt < 20), 1);
        ticks = 0; toggles = 0; prevClk = clkOut;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            ticks += int'(tickOut);
            if (clkOut != prevClk) toggles++;
            prevClk = clkOut;
        end
        checkOutput("full_ticks", 32'(ticks), 10);
        checkOutput("full_toggles", 32'(toggles), 10);

        $display("[TB] reset drops a staged ratio");
        applyStimulus(1, 1, 1, 1, 8);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("slow_num", 32'(activeNum), 1);
        applyStimulus(1, 1, 1, 1, 3);
        checkOutput("stage_ready_low", 32'(cfgReady), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rst2_num", 32'(activeNum), 4);
        checkOutput("rst2_den", 32'(activeDen), 5);
        checkOutput("rst2_ready", 32'(cfgReady), 1);
        checkOutput("rst2_tick", 32'(tickOut), 0);
        checkOutput("rst2_clk_out", 32'(clkOut), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            checkOutput("rst2_pattern", 32'(tickOut), (i == 0) ? 0 : 1);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 4) != 0),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 9)),
                          int'($urandom_range(0, 9)));
        end
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
